// File: rtl/arbitro_vc_destino.sv
// VC-to-destination arbiter: pops one VC head per cycle and pushes it, registered, to D0/D1.
// Optional round-robin between VCs is enabled with `define ARB_ROUND_ROBIN_EN (default: strict VC0 priority).
module arbitro_vc_destino #(
  parameter int BITBUS = 6,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active_in,
  input  logic [BITBUS-1:0] vc0_data,
  input  logic [BITBUS-1:0] vc1_data,
  input  logic              vc0_empty,
  input  logic              vc1_empty,
  input  logic              d0_almost_full,
  input  logic              d1_almost_full,
  output logic              vc0_pop,
  output logic              vc1_pop,
  output logic              d0_push,
  output logic              d1_push,
  output logic [BITBUS-1:0] d_data,
  output logic [CNT_W-1:0]  cnt_d0,
  output logic [CNT_W-1:0]  cnt_d1,
  output logic              idle
);

  logic              elig0, elig1;
  logic              grant0, grant1;
  logic [BITBUS-1:0] sel_data;
  logic              push0_d, push1_d, push0_q, push1_q;
  logic [BITBUS-1:0] data_d, data_q;
  logic [CNT_W-1:0]  cnt0_d, cnt1_d, cnt0_q, cnt1_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic              last_d, last_q;  // 1 = VC1 granted last, so VC0 preferred next
`endif

  always_comb begin
    // Each VC only looks at the almost-full of its own destination: no HOL coupling.
    elig0 = active_in & ~vc0_empty & ~reset &
            ~(vc0_data[BITBUS-1] ? d1_almost_full : d0_almost_full);
    elig1 = active_in & ~vc1_empty & ~reset &
            ~(vc1_data[BITBUS-1] ? d1_almost_full : d0_almost_full);

`ifdef ARB_ROUND_ROBIN_EN
    if (elig0 && elig1) begin
      grant0 = last_q;
      grant1 = ~last_q;
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
    last_d = last_q;
    if (grant0 || grant1) begin
      last_d = grant1;
    end
`else
    grant0 = elig0;
    grant1 = elig1 & ~elig0;
`endif

    sel_data = grant1 ? vc1_data : vc0_data;
    push0_d  = (grant0 | grant1) & ~sel_data[BITBUS-1];
    push1_d  = (grant0 | grant1) &  sel_data[BITBUS-1];
    data_d   = (grant0 | grant1) ? sel_data : data_q;
    cnt0_d   = cnt0_q + {{(CNT_W-1){1'b0}}, push0_d};
    cnt1_d   = cnt1_q + {{(CNT_W-1){1'b0}}, push1_d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push0_q <= 1'b0;
      push1_q <= 1'b0;
      data_q  <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= 1'b1;
`endif
    end else begin
      push0_q <= push0_d;
      push1_q <= push1_d;
      data_q  <= data_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  assign vc0_pop = grant0;
  assign vc1_pop = grant1;
  assign d0_push = push0_q;
  assign d1_push = push1_q;
  assign d_data  = data_q;
  assign cnt_d0  = cnt0_q;
  assign cnt_d1  = cnt1_q;
  assign idle    = ~push0_q & ~push1_q & vc0_empty & vc1_empty;

endmodule

// File: tb/tb_arbitro_vc_destino.sv
// Scoreboard bench for arbitro_vc_destino: expected pushes are queued at pop time and checked one edge later.
module tb_arbitro_vc_destino;

  logic       clk = 1'b0;
  logic       reset, active_in;
  logic [5:0] vc0_data, vc1_data;
  logic       vc0_empty, vc1_empty, d0_almost_full, d1_almost_full;
  logic       vc0_pop, vc1_pop, d0_push, d1_push, idle;
  logic [5:0] d_data;
  logic [7:0] cnt_d0, cnt_d1;

  arbitro_vc_destino #(.BITBUS(6), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .active_in(active_in),
    .vc0_data(vc0_data), .vc1_data(vc1_data),
    .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
    .vc0_pop(vc0_pop), .vc1_pop(vc1_pop),
    .d0_push(d0_push), .d1_push(d1_push), .d_data(d_data),
    .cnt_d0(cnt_d0), .cnt_d1(cnt_d1), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       dst;
    logic [5:0] data;
  } exp_t;

  exp_t       sb_q[$];
  int         chk_cnt = 0;
  int         pass_cnt = 0;
  logic       m_push0, m_push1, m_last;
  logic [5:0] m_data;
  logic [7:0] m_cnt0, m_cnt1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    sb_q.delete();
    m_push0 = 1'b0; m_push1 = 1'b0; m_data = '0;
    m_cnt0 = '0; m_cnt1 = '0; m_last = 1'b1;
  endtask

  // Called at posedge+1. rst_mid raises reset late in the cycle, after the pop, before the edge.
  task automatic cyc(input logic rst, input logic a, input logic e0, input logic e1,
                     input logic [5:0] dv0, input logic [5:0] dv1,
                     input logic af0, input logic af1, input logic rst_mid);
    logic el0, el1, g0, g1, blk0, blk1;
    exp_t e;
    reset = rst; active_in = a; vc0_empty = e0; vc1_empty = e1;
    vc0_data = dv0; vc1_data = dv1; d0_almost_full = af0; d1_almost_full = af1;
    if (rst) model_clear();
    #3;
    blk0 = dv0[5] ? af1 : af0;
    blk1 = dv1[5] ? af1 : af0;
    el0 = a & !e0 & !rst & !blk0;
    el1 = a & !e1 & !rst & !blk1;
`ifdef ARB_ROUND_ROBIN_EN
    if (el0 && el1) begin g0 = m_last; g1 = !m_last; end
    else begin g0 = el0; g1 = el1; end
`else
    g0 = el0; g1 = el1 && !el0;
`endif
    check_eq("vc0_pop", 32'(vc0_pop), 32'(g0));
    check_eq("vc1_pop", 32'(vc1_pop), 32'(g1));
    check_eq("idle", 32'(idle), 32'(!m_push0 && !m_push1 && e0 && e1));
    if (g0 || g1) m_last = g1;
    e.v = g0 | g1;
    e.data = g1 ? dv1 : dv0;
    e.dst = e.data[5];
    if (rst_mid) begin
      reset = 1'b1;
      model_clear();
      e.v = 1'b0;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      m_push0 = e.v & !e.dst;
      m_push1 = e.v & e.dst;
      if (e.v) m_data = e.data;
      m_cnt0 = m_cnt0 + 8'(m_push0);
      m_cnt1 = m_cnt1 + 8'(m_push1);
      check_eq("d0_push", 32'(d0_push), 32'(m_push0));
      check_eq("d1_push", 32'(d1_push), 32'(m_push1));
      check_eq("d_data", 32'(d_data), 32'(m_data));
      check_eq("cnt_d0", 32'(cnt_d0), 32'(m_cnt0));
      check_eq("cnt_d1", 32'(cnt_d1), 32'(m_cnt1));
    end
  endtask

  initial begin
    reset = 1'b1; active_in = 1'b0; vc0_empty = 1'b1; vc1_empty = 1'b1;
    vc0_data = '0; vc1_data = '0; d0_almost_full = 1'b0; d1_almost_full = 1'b0;
    model_clear();
    @(posedge clk); #1;

    // Reset held with both VCs full and active: no pops.
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0, 6'b000001, 6'b100010, 1'b0, 1'b0, 1'b0);
    // Released but inactive: no pops, counters stay 0.
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 6'b000001, 6'b100010, 1'b0, 1'b0, 1'b0);
    check_eq("cnt_d0_after_rst", 32'(cnt_d0), 32'd0);
    check_eq("cnt_d1_after_rst", 32'(cnt_d1), 32'd0);

    // Single VC0 word to D1, then drained.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 6'b100101, 6'b000000, 1'b0, 1'b0, 1'b0);
    check_eq("single_data", 32'(d_data), 32'h25);
    check_eq("single_cnt_d1", 32'(cnt_d1), 32'd1);
    repeat (2) cyc(1'b0, 1'b1, 1'b1, 1'b1, 6'b100101, 6'b000000, 1'b0, 1'b0, 1'b0);

    // Both VCs busy, free destinations: policy order.
    repeat (4) cyc(1'b0, 1'b1, 1'b0, 1'b0, 6'b000011, 6'b100110, 1'b0, 1'b0, 1'b0);

    // VC0 blocked by D0 almost-full must not stall VC1; release pops VC0 at once.
    repeat (4) cyc(1'b0, 1'b1, 1'b0, 1'b0, 6'b000111, 6'b101000, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 6'b000111, 6'b101000, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 6'b000111, 6'b101000, 1'b0, 1'b0, 1'b0);

    // Counter wrap: from reset, 256 pushes to D0 bring cnt_d0 back to 0.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 6'b0, 6'b0, 1'b0, 1'b0, 1'b0);
    repeat (255) cyc(1'b0, 1'b1, 1'b0, 1'b1, 6'b001010, 6'b0, 1'b0, 1'b0, 1'b0);
    check_eq("cnt_d0_255", 32'(cnt_d0), 32'd255);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 6'b001010, 6'b0, 1'b0, 1'b0, 1'b0);
    check_eq("cnt_d0_wrap", 32'(cnt_d0), 32'd0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      cyc(1'b0, ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 3) == 0), 6'($urandom), 6'($urandom),
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), 1'b0);
    end

    // Reset arriving after a pop discards the in-flight word.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 6'b000100, 6'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 6'b000101, 6'b0, 1'b0, 1'b0, 1'b1);
    check_eq("rst_mid_push0", 32'(d0_push), 32'd0);
    check_eq("rst_mid_cnt0", 32'(cnt_d0), 32'd0);
    repeat (2) cyc(1'b0, 1'b1, 1'b1, 1'b1, 6'b0, 6'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
